// File: rtl/led_serial_driver.sv
// Serialises an LED vector MSB-first onto a 74HC595-style chain (data, shift clock, latch).
// A frame is sent only when the vector differs from what the chain currently shows.
module led_serial_driver #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] led_in,
    output logic             ser_data,
    output logic             ser_clk,
    output logic             ser_latch,
    output logic             busy,
    output logic             frame_done,
    output logic [WIDTH-1:0] led_shown
);

    localparam int BIT_W = $clog2(WIDTH);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_LATCH
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   cap_q, cap_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               force_q, force_d;
    logic               ser_data_q, ser_data_d;
    logic               ser_clk_q, ser_clk_d;
    logic               ser_latch_q, ser_latch_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic [WIDTH-1:0]   led_shown_q, led_shown_d;
    logic               div_done;

    assign div_done = (div_cnt_q == LAST_DIV);

    // NOTE: sequential state uses non-blocking assignments so every register updates together at the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            cap_q        <= '0;
            bit_cnt_q    <= '0;
            div_cnt_q    <= '0;
            force_q      <= 1'b1;
            ser_data_q   <= 1'b0;
            ser_clk_q    <= 1'b0;
            ser_latch_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            led_shown_q  <= '0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cap_q        <= cap_d;
            bit_cnt_q    <= bit_cnt_d;
            div_cnt_q    <= div_cnt_d;
            force_q      <= force_d;
            ser_data_q   <= ser_data_d;
            ser_clk_q    <= ser_clk_d;
            ser_latch_q  <= ser_latch_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            led_shown_q  <= led_shown_d;
        end
    end

    // NOTE: every next-state signal gets a default first so no latch can be inferred.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cap_d        = cap_q;
        bit_cnt_d    = bit_cnt_q;
        div_cnt_d    = div_cnt_q;
        force_d      = force_q;
        ser_data_d   = ser_data_q;
        ser_clk_d    = ser_clk_q;
        ser_latch_d  = ser_latch_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        led_shown_d  = led_shown_q;

        case (state_q)
            S_IDLE: begin
                // The forced frame after reset puts the chain into a known state even for an all-zero vector.
                if (force_q || (led_in != led_shown_q)) begin
                    cap_d      = led_in;
                    shreg_d    = led_in;
                    ser_data_d = led_in[WIDTH-1];
                    bit_cnt_d  = '0;
                    div_cnt_d  = '0;
                    force_d    = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_LOW;
                end
            end

            S_LOW: begin
                if (div_done) begin
                    div_cnt_d = '0;
                    ser_clk_d = 1'b1;
                    state_d   = S_HIGH;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            S_HIGH: begin
                if (div_done) begin
                    div_cnt_d = '0;
                    ser_clk_d = 1'b0;
                    if (bit_cnt_q == LAST_BIT) begin
                        ser_latch_d = 1'b1;
                        state_d     = S_LATCH;
                    end else begin
                        // Data moves only on entry to LOW, giving a full half-period of setup before the rise.
                        shreg_d    = shreg_q << 1;
                        ser_data_d = shreg_q[WIDTH-2];
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        state_d    = S_LOW;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            S_LATCH: begin
                if (div_done) begin
                    div_cnt_d    = '0;
                    ser_latch_d  = 1'b0;
                    led_shown_d  = cap_q;
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    ser_data_d   = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ser_data   = ser_data_q;
    assign ser_clk    = ser_clk_q;
    assign ser_latch  = ser_latch_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign led_shown  = led_shown_q;

`ifndef SYNTHESIS
    a_latch_only_in_latch : assert property (@(posedge clk) disable iff (!reset)
        ser_latch_q |-> (state_q == S_LATCH));
    a_busy_tracks_state : assert property (@(posedge clk) disable iff (!reset)
        busy_q == (state_q != S_IDLE));
`endif

endmodule

// File: tb/tb_led_serial_driver.sv
// Scoreboard bench for led_serial_driver: stimulus pushes expected latched frames,
// monitors rebuild each frame from the serial pins and compare on frame_done.
module tb_led_serial_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        rst8;
    logic [15:0] led_in;
    logic [7:0]  led8;

    logic        ser_data, ser_clk, ser_latch, busy, frame_done;
    logic [15:0] led_shown;
    logic        ser_data8, ser_clk8, ser_latch8, busy8, frame_done8;
    logic [7:0]  led_shown8;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  exp8_q[$];
    int done_cnt    = 0;
    int done8_cnt   = 0;
    int total_rises = 0;

    always #5 clk = ~clk;

    led_serial_driver #(.WIDTH(16), .CLK_DIV(2)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .led_in     (led_in),
        .ser_data   (ser_data),
        .ser_clk    (ser_clk),
        .ser_latch  (ser_latch),
        .busy       (busy),
        .frame_done (frame_done),
        .led_shown  (led_shown)
    );

    led_serial_driver #(.WIDTH(8), .CLK_DIV(1)) u_dut8 (
        .clk        (clk),
        .reset      (rst8),
        .led_in     (led8),
        .ser_data   (ser_data8),
        .ser_clk    (ser_clk8),
        .ser_latch  (ser_latch8),
        .busy       (busy8),
        .frame_done (frame_done8),
        .led_shown  (led_shown8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the 16-bit / CLK_DIV=2 instance.
    int          rises, busy_cnt, latch_cnt;
    logic [15:0] bits;
    logic        prev_clk;
    logic [15:0] e16;

    always @(negedge clk) begin
        if (!reset) begin
            rises = 0; busy_cnt = 0; latch_cnt = 0; bits = '0; prev_clk = 1'b0;
        end else begin
            if (ser_clk && !prev_clk) begin
                rises++;
                total_rises++;
                bits = {bits[14:0], ser_data};
            end
            prev_clk = ser_clk;
            if (busy) busy_cnt++;
            if (ser_latch) latch_cnt++;
            if (frame_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'(exp_q.size()), 32'd1);
                end else begin
                    e16 = exp_q.pop_front();
                    check("frame_bits", bits, e16);
                    check("frame_rises", rises, 16);
                    check("frame_busy_len", busy_cnt, 66);
                    check("frame_latch_len", latch_cnt, 2);
                    check("frame_led_shown", led_shown, e16);
                    check("frame_busy_low", busy, 0);
                end
                rises = 0; busy_cnt = 0; latch_cnt = 0; bits = '0;
                done_cnt++;
            end
        end
    end

    // Monitor for the 8-bit / CLK_DIV=1 instance.
    int          rises8, busy8_cnt, latch8_cnt;
    logic [7:0]  bits8;
    logic        prev_clk8;
    logic [7:0]  e8;

    always @(negedge clk) begin
        if (!rst8) begin
            rises8 = 0; busy8_cnt = 0; latch8_cnt = 0; bits8 = '0; prev_clk8 = 1'b0;
        end else begin
            if (ser_clk8 && !prev_clk8) begin
                rises8++;
                bits8 = {bits8[6:0], ser_data8};
            end
            prev_clk8 = ser_clk8;
            if (busy8) busy8_cnt++;
            if (ser_latch8) latch8_cnt++;
            if (frame_done8) begin
                if (exp8_q.size() == 0) begin
                    check("w8_unexpected_frame", 32'(exp8_q.size()), 32'd1);
                end else begin
                    e8 = exp8_q.pop_front();
                    check("w8_bits", bits8, e8);
                    check("w8_rises", rises8, 8);
                    check("w8_busy_len", busy8_cnt, 17);
                    check("w8_latch_len", latch8_cnt, 1);
                    check("w8_led_shown", led_shown8, e8);
                end
                rises8 = 0; busy8_cnt = 0; latch8_cnt = 0; bits8 = '0;
                done8_cnt++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns 1 ns after the first rising edge that follows the target frame_done.
    task automatic wait_done(input int target, input string name);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (done_cnt >= target) break;
        end
        #1;
        check(name, done_cnt, target);
    endtask

    int nf = 0;
    int r0;

    initial begin
        reset  = 1'b0;
        rst8   = 1'b0;
        led_in = 16'h0000;
        led8   = 8'hA5;
        step(3);

        // Reset values, then the forced frame of an all-zero vector.
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ser_clk", ser_clk, 0);
        check("rst_led_shown", led_shown, 16'h0000);
        step(1);
        exp_q.push_back(16'h0000);
        exp8_q.push_back(8'hA5);
        reset = 1'b1;
        rst8  = 1'b1;
        nf++; wait_done(nf, "t1_forced_frame");

        // No change: chain stays quiet.
        r0 = total_rises;
        step(200);
        check("t1_idle_no_clk", total_rises, r0);
        check("t1_idle_busy", busy, 0);

        // Single-change frame with the two end bits set.
        led_in = 16'h8001;
        exp_q.push_back(16'h8001);
        nf++; wait_done(nf, "t2_frame");
        step(5);

        // Sweep every 10 cycles: starts at +1, +68, +135, +202 pick up 0001, 007F, 3FFF, FFFF.
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h007F);
        exp_q.push_back(16'h3FFF);
        exp_q.push_back(16'hFFFF);
        for (int j = 0; j < 16; j++) begin
            led_in = 16'((32'h1 << (j + 1)) - 32'h1);
            step(10);
        end
        nf += 4; wait_done(nf, "t3_sweep_frames");
        check("t3_final_shown", led_shown, led_in);
        step(5);

        // Mid-frame change is held back to the next frame, which follows after one idle cycle.
        led_in = 16'h00FF;
        exp_q.push_back(16'h00FF);
        exp_q.push_back(16'hFF00);
        step(30);
        led_in = 16'hFF00;
        nf++; wait_done(nf, "t4_first_frame");
        @(negedge clk);
        check("t4_back_to_back_busy", busy, 1);
        nf++; wait_done(nf, "t4_second_frame");
        step(5);

        // Reset 20 cycles into a frame abandons it without a latch.
        led_in = 16'h1234;
        step(20);
        exp_q.delete();
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_ser_clk", ser_clk, 0);
        check("t5_rst_latch", ser_latch, 0);
        check("t5_rst_shown", led_shown, 16'h0000);
        check("t5_rst_data", ser_data, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_rst_hold_latch", ser_latch, 0);
        end
        exp_q.push_back(16'h1234);
        @(posedge clk);
        #1;
        reset = 1'b1;
        nf++; wait_done(nf, "t5_forced_frame");
        check("t5_final_shown", led_shown, 16'h1234);

        step(5);
        check("w8_frames", done8_cnt, 1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
